// File: rtl/sum_accum_pkg.sv
// Shared types and default widths for the sum accumulator block.
package sum_accum_pkg;

  localparam int SUM_W = 4;
  localparam int ACC_W = 8;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sum_accum_ripple_add.sv
// W-bit ripple-carry adder assembled from 1-bit full-adder cells.
module ripple_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign cout = carry_s[W];

endmodule

// File: rtl/sum_accum.sv
// Accumulates a programmed number of adder sums and hands the total to a
// valid/ready sink, with a sticky overflow flag.
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int SUM_W_P = SUM_W,
  parameter int ACC_W_P = ACC_W,
  parameter int CNT_W_P = CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W_P-1:0] len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SUM_W_P-1:0] in_sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W_P-1:0] out_acc,
  output logic               out_ovf,
  output logic               busy
);

  localparam logic [CNT_W_P-1:0] CNT_ZERO = {CNT_W_P{1'b0}};
  localparam logic [CNT_W_P-1:0] CNT_ONE  = {{(CNT_W_P-1){1'b0}}, 1'b1};
  localparam logic [ACC_W_P-1:0] ACC_ZERO = {ACC_W_P{1'b0}};

  state_e               state_q, state_d;
  logic [ACC_W_P-1:0]   acc_q, acc_d;
  logic [CNT_W_P-1:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_W_P-1:0]   out_acc_q, out_acc_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 busy_q, busy_d;

  logic [ACC_W_P-1:0]   add_sum_s;
  logic                 add_cout_s;
  logic                 xfer_s;

  ripple_add #(.W(ACC_W_P)) u_add (
    .a    (acc_q),
    .b    ({{(ACC_W_P-SUM_W_P){1'b0}}, in_sum}),
    .cin  (1'b0),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  assign xfer_s = in_valid & in_ready_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_acc_d = out_acc_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = ACC_ZERO;
          ovf_d = 1'b0;
          if (len != CNT_ZERO) begin
            cnt_d   = len;
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (xfer_s) begin
          acc_d = add_sum_s;
          ovf_d = ovf_q | add_cout_s;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Result registers capture once on entry to DONE so they stay frozen while the sink stalls.
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      out_acc_d = acc_d;
      out_ovf_d = ovf_d;
    end else begin
      out_acc_d = out_acc_q;
      out_ovf_d = out_ovf_q;
    end

    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= ACC_ZERO;
      cnt_q       <= CNT_ZERO;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= ACC_ZERO;
      out_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum: an integer-total reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_sum_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_sum;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_acc;
  logic       out_ovf;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // reference model: plain integer total and remaining-count bookkeeping
  bit m_running = 1'b0;
  bit m_result  = 1'b0;
  int m_left    = 0;
  int m_total   = 0;

  sum_accum dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_step();
    if (rst) begin
      m_running = 1'b0;
      m_result  = 1'b0;
      m_left    = 0;
      m_total   = 0;
    end else if (m_running) begin
      if (in_valid) begin
        m_total = m_total + int'(in_sum);
        m_left  = m_left - 1;
        if (m_left == 0) begin
          m_running = 1'b0;
          m_result  = 1'b1;
        end
      end
    end else if (m_result) begin
      if (out_ready) m_result = 1'b0;
    end else if (start) begin
      m_total = 0;
      if (len == 5'd0) begin
        m_result = 1'b1;
      end else begin
        m_running = 1'b1;
        m_left    = int'(len);
      end
    end
  endtask

  always @(posedge clk) mdl_step();

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready", int'(in_ready), int'(m_running));
      chk("m_out_valid", int'(out_valid), int'(m_result));
      chk("m_busy", int'(busy), int'(m_running | m_result));
      if (m_result) begin
        chk("m_out_acc", int'(out_acc), m_total % 256);
        chk("m_out_ovf", int'(out_ovf), int'(m_total > 255));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input int n);
    start = 1'b1;
    len   = n[4:0];
    step();
    start = 1'b0;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_sum   = v[3:0];
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    if (!out_valid) chk("timeout_out_valid", 0, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hs_out_valid_low", int'(out_valid), 0);
    chk("hs_busy_low", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 5'd0; in_valid = 1'b0; in_sum = 4'd0; out_ready = 1'b0;
    step();
    step();
    chk_en = 1'b1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_acc", int'(out_acc), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    step();

    // 1: three sums back-to-back, result visible one cycle after last transfer
    begin_run(3);
    chk("t1_in_ready", int'(in_ready), 1);
    send(5); send(7); send(2);
    chk("t1_latency", int'(out_valid), 1);
    chk("t1_acc", int'(out_acc), 14);
    chk("t1_ovf", int'(out_ovf), 0);
    handshake();

    // 2: eighteen 15s wrap the 8-bit total
    begin_run(18);
    for (int i = 0; i < 18; i++) send(15);
    wait_done();
    chk("t2_acc", int'(out_acc), 14);
    chk("t2_ovf", int'(out_ovf), 1);
    handshake();

    // 3: zero-length run goes straight to DONE
    begin_run(0);
    chk("t3_valid", int'(out_valid), 1);
    chk("t3_in_ready", int'(in_ready), 0);
    chk("t3_acc", int'(out_acc), 0);
    chk("t3_ovf", int'(out_ovf), 0);
    handshake();

    // 4: bubbles between two sums
    begin_run(2);
    send(3);
    for (int i = 0; i < 4; i++) begin
      in_sum = 4'd15;
      step();
      chk("t4_no_valid", int'(out_valid), 0);
    end
    send(3);
    chk("t4_acc", int'(out_acc), 6);

    // 5: stalled sink while start/in_valid toggle
    for (int i = 0; i < 5; i++) begin
      start    = i[0];
      in_valid = ~i[0];
      len      = 5'd7;
      in_sum   = 4'd9;
      step();
      chk("t5_acc_stable", int'(out_acc), 6);
      chk("t5_valid_stable", int'(out_valid), 1);
      chk("t5_in_ready", int'(in_ready), 0);
    end
    start = 1'b0; in_valid = 1'b0;
    handshake();

    // 6: reset mid-run discards the partial result
    begin_run(4);
    send(1); send(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_in_ready", int'(in_ready), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_acc", int'(out_acc), 0);
    chk("t6_rst_ovf", int'(out_ovf), 0);
    begin_run(1);
    send(9);
    chk("t6_acc", int'(out_acc), 9);
    chk("t6_ovf", int'(out_ovf), 0);
    handshake();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
